// File: rtl/ppu_spr_eval.sv
// Per-scanline sprite evaluation: scans the 64 primary-OAM entries and copies up to
// NUM_SPR in-range sprites into a private secondary OAM for the pattern-fetch stage.
module ppu_spr_eval #(
  parameter  int NUM_SPR = 8,
  localparam int SAW     = $clog2(4 * NUM_SPR),
  localparam int CW      = $clog2(NUM_SPR) + 1
) (
  input  logic           clk_in,
  input  logic           rst_in,
  input  logic           start_in,
  input  logic [7:0]     scanline_in,
  input  logic           spr_h16_in,
  output logic [7:0]     spr_ram_a_out,
  input  logic [7:0]     spr_ram_d_in,
  input  logic [SAW-1:0] sec_a_in,
  output logic [7:0]     sec_d_out,
  output logic           busy_out,
  output logic           done_out,
  output logic [CW-1:0]  count_out,
  output logic           overflow_out,
  output logic           spr0_out
);

  typedef enum logic [2:0] {IDLE, CLEAR, EVAL, COPY1, COPY2, COPY3, DONE} state_t;

  state_t         state_q, state_d;
  logic [7:0]     sec_q [4*NUM_SPR];
  logic [7:0]     scan_q;
  logic           h16_q;
  logic [5:0]     n_q;
  logic [SAW-1:0] idx_q;
  logic [CW-1:0]  count_q;
  logic           overflow_q, spr0_q;

  logic [8:0]     diff;
  logic           in_range, full;
  logic           sec_we;
  logic [SAW-1:0] sec_wa, slot_base;
  logic [7:0]     sec_wd;

  assign full      = (count_q == CW'(NUM_SPR));
  assign slot_base = {count_q[CW-2:0], 2'b00};

  // NOTE: every always_comb output gets a default before the case so no latch is inferred.
  always_comb begin
    diff          = {1'b0, scan_q} - {1'b0, spr_ram_d_in};
    in_range      = !diff[8] && (diff[7:0] < (h16_q ? 8'd16 : 8'd8));
    state_d       = state_q;
    spr_ram_a_out = 8'h00;
    sec_we        = 1'b0;
    sec_wa        = slot_base;
    sec_wd        = spr_ram_d_in;
    done_out      = 1'b0;
    unique case (state_q)
      IDLE: ;
      CLEAR: begin
        sec_we = 1'b1;
        sec_wa = idx_q;
        sec_wd = 8'hFF;
        if (idx_q == SAW'(4 * NUM_SPR - 1)) state_d = EVAL;
      end
      EVAL: begin
        spr_ram_a_out = {n_q, 2'b00};
        if (in_range) begin
          if (full) state_d = DONE;
          else begin
            sec_we  = 1'b1;
            state_d = COPY1;
          end
        end else if (n_q == 6'd63) begin
          state_d = DONE;
        end
      end
      COPY1: begin
        spr_ram_a_out = {n_q, 2'b01};
        sec_we        = 1'b1;
        sec_wa        = slot_base | SAW'(1);
        state_d       = COPY2;
      end
      COPY2: begin
        spr_ram_a_out = {n_q, 2'b10};
        sec_we        = 1'b1;
        sec_wa        = slot_base | SAW'(2);
        state_d       = COPY3;
      end
      COPY3: begin
        spr_ram_a_out = {n_q, 2'b11};
        sec_we        = 1'b1;
        sec_wa        = slot_base | SAW'(3);
        state_d       = (n_q == 6'd63) ? DONE : EVAL;
      end
      DONE: begin
        done_out = 1'b1;
        state_d  = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // A start pulse always wins, including as an abort of a pass in flight.
    if (start_in) state_d = CLEAR;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) state_q <= IDLE;
    else         state_q <= state_d;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      scan_q     <= 8'h00;
      h16_q      <= 1'b0;
      n_q        <= 6'd0;
      idx_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      spr0_q     <= 1'b0;
    end else if (start_in) begin
      scan_q     <= scanline_in;
      h16_q      <= spr_h16_in;
      n_q        <= 6'd0;
      idx_q      <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      spr0_q     <= 1'b0;
    end else begin
      unique case (state_q)
        CLEAR: idx_q <= idx_q + SAW'(1);
        EVAL: begin
          if (in_range && full)      overflow_q <= 1'b1;
          else if (in_range)         spr0_q     <= spr0_q | (n_q == 6'd0);
          else if (n_q != 6'd63)     n_q        <= n_q + 6'd1;
        end
        COPY3: begin
          count_q <= count_q + CW'(1);
          if (n_q != 6'd63) n_q <= n_q + 6'd1;
        end
        default: ;
      endcase
    end
  end

  // NOTE: the secondary OAM is reset because unused slots must read 0xFF straight out of reset.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < 4 * NUM_SPR; i++) sec_q[i] <= 8'hFF;
    end else if (sec_we && !start_in) begin
      sec_q[sec_wa] <= sec_wd;
    end
  end

  assign sec_d_out    = sec_q[sec_a_in];
  assign busy_out     = (state_q != IDLE);
  assign count_out    = count_q;
  assign overflow_out = overflow_q;
  assign spr0_out     = spr0_q;

endmodule

// File: tb/tb_ppu_spr_eval.sv
// Directed bench for ppu_spr_eval: a behavioural primary OAM drives the read port and
// each scenario checks latency, result flags and secondary-OAM contents.
module tb_ppu_spr_eval;

  logic       clk_in = 1'b0;
  logic       rst_in, start_in, spr_h16_in;
  logic [7:0] scanline_in, spr_ram_a_out, spr_ram_d_in, sec_d_out;
  logic [4:0] sec_a_in;
  logic       busy_out, done_out, overflow_out, spr0_out;
  logic [3:0] count_out;

  logic [7:0] oam [256];
  int n_checks = 0;
  int n_pass   = 0;
  bit done_seen;

  assign spr_ram_d_in = oam[spr_ram_a_out];

  ppu_spr_eval #(.NUM_SPR(8)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .start_in(start_in), .scanline_in(scanline_in),
    .spr_h16_in(spr_h16_in), .spr_ram_a_out(spr_ram_a_out), .spr_ram_d_in(spr_ram_d_in),
    .sec_a_in(sec_a_in), .sec_d_out(sec_d_out), .busy_out(busy_out), .done_out(done_out),
    .count_out(count_out), .overflow_out(overflow_out), .spr0_out(spr0_out)
  );

  always #10 clk_in = ~clk_in;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk_in);
    #1;
    if (done_out) done_seen = 1'b1;
  endtask

  task automatic fill_oam();
    for (int i = 0; i < 256; i++) oam[i] = 8'hF0;
  endtask

  task automatic sec_read(input int a, output logic [7:0] d);
    sec_a_in = 5'(a);
    #1;
    d = sec_d_out;
  endtask

  task automatic check_sec_all_ff(input string tag);
    logic [7:0] d;
    int bad = 0;
    for (int a = 0; a < 32; a++) begin
      sec_read(a, d);
      if (d !== 8'hFF) bad++;
    end
    check(tag, 16'(bad), 16'd0);
  endtask

  task automatic pulse_start(input logic [7:0] scan, input logic h16);
    scanline_in = scan;
    spr_h16_in  = h16;
    start_in    = 1'b1;
    done_seen   = 1'b0;
    step();
    start_in    = 1'b0;
  endtask

  // Runs a pass to completion; cycles counted from the cycle that presented start_in.
  task automatic run_pass(input string tag, input logic [7:0] scan, input logic h16,
                          input int exp_cyc, input int exp_cnt, input bit exp_ovf,
                          input bit exp_spr0);
    int cyc;
    pulse_start(scan, h16);
    cyc = 1;
    while (!done_out && cyc < 400) begin
      step();
      cyc++;
    end
    check({tag, "_done_seen"}, 16'(done_out), 16'd1);
    check({tag, "_latency"}, 16'(cyc), 16'(exp_cyc));
    check({tag, "_busy_in_done"}, 16'(busy_out), 16'd1);
    step();
    check({tag, "_done_pulse"}, 16'(done_out), 16'd0);
    check({tag, "_idle"}, 16'(busy_out), 16'd0);
    check({tag, "_count"}, 16'(count_out), 16'(exp_cnt));
    check({tag, "_ovf"}, 16'(overflow_out), 16'(exp_ovf));
    check({tag, "_spr0"}, 16'(spr0_out), 16'(exp_spr0));
  endtask

  logic [7:0] d;

  initial begin
    rst_in = 1'b0; start_in = 1'b0; spr_h16_in = 1'b0; scanline_in = 8'h00; sec_a_in = 5'd0;
    fill_oam();
    step(); step();
    check("rst_busy", 16'(busy_out), 16'd0);
    check("rst_done", 16'(done_out), 16'd0);
    check("rst_count", 16'(count_out), 16'd0);
    check("rst_ovf", 16'(overflow_out), 16'd0);
    check("rst_spr0", 16'(spr0_out), 16'd0);
    check("rst_addr", 16'(spr_ram_a_out), 16'h00);
    check_sec_all_ff("rst_sec");
    rst_in = 1'b1;
    step();

    // No sprite on the line.
    run_pass("empty", 8'd10, 1'b0, 97, 0, 1'b0, 1'b0);
    check("empty_addr_idle", 16'(spr_ram_a_out), 16'h00);
    check_sec_all_ff("empty_sec");

    // Sprite 0 on the bottom row of its 8-line span.
    oam[0] = 8'h20; oam[1] = 8'h11; oam[2] = 8'h22; oam[3] = 8'h33;
    run_pass("spr0", 8'h27, 1'b0, 100, 1, 1'b0, 1'b1);
    sec_read(0, d); check("spr0_sec0", 16'(d), 16'h20);
    sec_read(1, d); check("spr0_sec1", 16'(d), 16'h11);
    sec_read(2, d); check("spr0_sec2", 16'(d), 16'h22);
    sec_read(3, d); check("spr0_sec3", 16'(d), 16'h33);
    sec_read(4, d); check("spr0_sec4", 16'(d), 16'hFF);

    // Height boundary: diff = 8 misses 8x8, hits 8x16.
    run_pass("h8_edge", 8'h28, 1'b0, 97, 0, 1'b0, 1'b0);
    run_pass("h16_edge", 8'h28, 1'b1, 100, 1, 1'b0, 1'b1);

    // Ten sprites on the line: 5..12 copied, 13 overflows.
    fill_oam();
    for (int k = 5; k <= 14; k++) begin
      oam[4*k]   = 8'h40;
      oam[4*k+1] = 8'(k);
      oam[4*k+2] = 8'(8'h80 + k);
      oam[4*k+3] = 8'(8'hC0 + k);
    end
    run_pass("ovf", 8'h42, 1'b0, 71, 8, 1'b1, 1'b0);
    for (int s = 0; s < 8; s++) begin
      sec_read(4*s, d);   check($sformatf("ovf_y%0d", s), 16'(d), 16'h40);
      sec_read(4*s+1, d); check($sformatf("ovf_tile%0d", s), 16'(d), 16'(5 + s));
      sec_read(4*s+3, d); check($sformatf("ovf_x%0d", s), 16'(d), 16'(8'hC0 + 5 + s));
    end

    // Restart 50 cycles into a pass that would have found sprite 0.
    fill_oam();
    oam[0] = 8'h20; oam[1] = 8'h11; oam[2] = 8'h22; oam[3] = 8'h33;
    pulse_start(8'h27, 1'b0);
    for (int i = 1; i < 50; i++) step();
    check("restart_no_early_done", 16'(done_seen), 16'd0);
    run_pass("restart", 8'h30, 1'b0, 97, 0, 1'b0, 1'b0);
    check_sec_all_ff("restart_sec");

    // Asynchronous reset during COPY2 of sprite 0.
    pulse_start(8'h27, 1'b0);
    for (int i = 1; i < 35; i++) step();
    check("copy2_addr", 16'(spr_ram_a_out), 16'h02);
    check("copy2_spr0", 16'(spr0_out), 16'd1);
    rst_in = 1'b0;
    #1;
    check("arst_busy", 16'(busy_out), 16'd0);
    check("arst_spr0", 16'(spr0_out), 16'd0);
    check("arst_addr", 16'(spr_ram_a_out), 16'h00);
    check_sec_all_ff("arst_sec");
    step(); step();
    check("arst_no_done", 16'(done_seen), 16'd0);
    rst_in = 1'b1;
    step();
    fill_oam();
    run_pass("post_rst", 8'd10, 1'b0, 97, 0, 1'b0, 1'b0);
    check_sec_all_ff("post_rst_sec");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
